// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the Ethernet receive path.
// The CRC constants are also used by the TX framer.
package eth_rx_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } rx_state_t;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  localparam int unsigned ETH_FCS_BYTES = 4;
  // One payload byte plus the FCS must be held back so the FCS is never emitted.
  localparam int unsigned DLY_BYTES     = ETH_FCS_BYTES + 1;

  localparam logic [1:0] DIBIT_PRE = 2'b01;
  localparam logic [1:0] DIBIT_SFD = 2'b11;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 (reflected) advance by one data byte, LSB first.
module crc32_d8
  import eth_rx_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  always_comb begin
    o_crc = i_crc;
    for (int unsigned i = 0; i < 8; i++) begin
      if (o_crc[0] ^ i_data[i]) begin
        o_crc = (o_crc >> 1) ^ CRC32_POLY_REFL;
      end else begin
        o_crc = o_crc >> 1;
      end
    end
  end

endmodule

// File: rtl/rmii_rx_framer.sv
// RMII receive framer: strips preamble/SFD, assembles bytes, checks FCS and
// length, and emits the payload (FCS removed) with last/error flags.
module rmii_rx_framer
  import eth_rx_pkg::*;
#(
  parameter int unsigned MIN_PREAMBLE = 4,
  parameter int unsigned MAX_LEN      = 1522,
  parameter int unsigned MIN_LEN      = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rmii_crs_dv,
  input  logic [1:0]  rmii_rxd,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  output logic        m_err,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
);

  localparam int unsigned DLY_W = 8 * DLY_BYTES;

  rx_state_t        r_state, w_state_n;
  logic             r_low, w_low_n;
  logic [4:0]       r_pre_cnt, w_pre_cnt_n;
  logic [1:0]       r_idx, w_idx_n;
  logic [7:0]       r_sr, w_sr_n;
  logic             r_pend, w_pend_n;
  logic [1:0]       r_pend_dibit, w_pend_dibit_n;
  logic [31:0]      r_crc, w_crc_n;
  logic [DLY_W-1:0] r_dly, w_dly_n;
  logic [2:0]       r_dly_cnt, w_dly_cnt_n;
  logic [11:0]      r_byte_cnt, w_byte_cnt_n;
  logic [7:0]       r_data, w_data_n;
  logic             r_valid, w_valid_n;
  logic             r_last, w_last_n;
  logic             r_err, w_err_n;
  logic [15:0]      r_frame_cnt, w_frame_cnt_n;
  logic [15:0]      r_err_cnt, w_err_cnt_n;

  logic [1:0]       w_idx_asm;
  logic [7:0]       w_sr_asm;
  logic             w_byte_done;
  logic [7:0]       w_byte;
  logic [31:0]      w_crc_upd;
  logic             w_eof_err;
  logic [7:0]       w_oldest;

  // A held (crs_dv=0) dibit is committed ahead of the current one; at most one
  // of the two can complete a byte, so a single CRC stage suffices.
  always_comb begin
    w_idx_asm   = r_idx;
    w_sr_asm    = r_sr;
    w_byte_done = 1'b0;
    w_byte      = r_sr;
    if (r_pend) begin
      w_sr_asm[{w_idx_asm, 1'b0} +: 2] = r_pend_dibit;
      if (w_idx_asm == 2'd3) begin
        w_byte_done = 1'b1;
        w_byte      = w_sr_asm;
      end
      w_idx_asm = w_idx_asm + 2'd1;
    end
    w_sr_asm[{w_idx_asm, 1'b0} +: 2] = rmii_rxd;
    if (w_idx_asm == 2'd3) begin
      w_byte_done = 1'b1;
      w_byte      = w_sr_asm;
    end
    w_idx_asm = w_idx_asm + 2'd1;
  end

  crc32_d8 u_crc (
    .i_crc  (r_crc),
    .i_data (w_byte),
    .o_crc  (w_crc_upd)
  );

  assign w_oldest  = r_dly[DLY_W-1 -: 8];
  assign w_eof_err = (r_crc != CRC32_RESIDUE) || (r_idx != 2'd0) ||
                     (r_byte_cnt < 12'(MIN_LEN));

  always_comb begin
    w_state_n      = r_state;
    w_low_n        = r_low;
    w_pre_cnt_n    = r_pre_cnt;
    w_idx_n        = r_idx;
    w_sr_n         = r_sr;
    w_pend_n       = r_pend;
    w_pend_dibit_n = r_pend_dibit;
    w_crc_n        = r_crc;
    w_dly_n        = r_dly;
    w_dly_cnt_n    = r_dly_cnt;
    w_byte_cnt_n   = r_byte_cnt;
    w_data_n       = r_data;
    w_valid_n      = 1'b0;
    w_last_n       = 1'b0;
    w_err_n        = 1'b0;
    w_frame_cnt_n  = r_frame_cnt;
    w_err_cnt_n    = r_err_cnt;

    unique case (r_state)
      WAIT_IDLE, DROP: begin
        w_low_n = ~rmii_crs_dv;
        if (!rmii_crs_dv && r_low) begin
          w_state_n = IDLE;
        end
      end

      IDLE: begin
        if (rmii_crs_dv && (rmii_rxd == DIBIT_PRE)) begin
          w_state_n   = PREAMBLE;
          w_pre_cnt_n = 5'd1;
        end
      end

      PREAMBLE: begin
        if (!rmii_crs_dv) begin
          w_state_n = IDLE;
        end else if (rmii_rxd == DIBIT_PRE) begin
          if (r_pre_cnt != '1) begin
            w_pre_cnt_n = r_pre_cnt + 5'd1;
          end
        end else if ((rmii_rxd == DIBIT_SFD) && (r_pre_cnt >= 5'(MIN_PREAMBLE))) begin
          w_state_n    = DATA;
          w_idx_n      = 2'd0;
          w_sr_n       = '0;
          w_pend_n     = 1'b0;
          w_crc_n      = CRC32_INIT;
          w_dly_n      = '0;
          w_dly_cnt_n  = 3'd0;
          w_byte_cnt_n = '0;
        end else begin
          w_state_n = DROP;
          w_low_n   = 1'b0;
        end
      end

      DATA: begin
        if (!rmii_crs_dv) begin
          if (r_pend) begin
            // Second low in a row: end of frame, the held dibit is dropped.
            w_state_n = IDLE;
            w_pend_n  = 1'b0;
            if (r_dly_cnt == 3'(DLY_BYTES)) begin
              w_valid_n     = 1'b1;
              w_last_n      = 1'b1;
              w_err_n       = w_eof_err;
              w_data_n      = w_oldest;
              w_frame_cnt_n = sat_inc16(r_frame_cnt);
              if (w_eof_err) begin
                w_err_cnt_n = sat_inc16(r_err_cnt);
              end
            end else begin
              w_err_cnt_n = sat_inc16(r_err_cnt);
            end
          end else begin
            w_pend_n       = 1'b1;
            w_pend_dibit_n = rmii_rxd;
          end
        end else begin
          w_pend_n = 1'b0;
          w_idx_n  = w_idx_asm;
          w_sr_n   = w_sr_asm;
          if (w_byte_done) begin
            w_crc_n      = w_crc_upd;
            w_dly_n      = {r_dly[DLY_W-9:0], w_byte};
            w_byte_cnt_n = r_byte_cnt + 12'd1;
            if (r_dly_cnt == 3'(DLY_BYTES)) begin
              w_valid_n = 1'b1;
              w_data_n  = w_oldest;
            end else begin
              w_dly_cnt_n = r_dly_cnt + 3'd1;
            end
            // Overlength: the byte evicted now closes the frame as an error.
            if (r_byte_cnt == 12'(MAX_LEN)) begin
              w_last_n      = 1'b1;
              w_err_n       = 1'b1;
              w_frame_cnt_n = sat_inc16(r_frame_cnt);
              w_err_cnt_n   = sat_inc16(r_err_cnt);
              w_state_n     = DROP;
              w_low_n       = 1'b0;
            end
          end
        end
      end

      default: begin
        w_state_n = WAIT_IDLE;
        w_low_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= WAIT_IDLE;
      r_low        <= 1'b0;
      r_pre_cnt    <= '0;
      r_idx        <= '0;
      r_sr         <= '0;
      r_pend       <= 1'b0;
      r_pend_dibit <= '0;
      r_crc        <= CRC32_INIT;
      r_dly        <= '0;
      r_dly_cnt    <= '0;
      r_byte_cnt   <= '0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_last       <= 1'b0;
      r_err        <= 1'b0;
      r_frame_cnt  <= '0;
      r_err_cnt    <= '0;
    end else begin
      r_state      <= w_state_n;
      r_low        <= w_low_n;
      r_pre_cnt    <= w_pre_cnt_n;
      r_idx        <= w_idx_n;
      r_sr         <= w_sr_n;
      r_pend       <= w_pend_n;
      r_pend_dibit <= w_pend_dibit_n;
      r_crc        <= w_crc_n;
      r_dly        <= w_dly_n;
      r_dly_cnt    <= w_dly_cnt_n;
      r_byte_cnt   <= w_byte_cnt_n;
      r_data       <= w_data_n;
      r_valid      <= w_valid_n;
      r_last       <= w_last_n;
      r_err        <= w_err_n;
      r_frame_cnt  <= w_frame_cnt_n;
      r_err_cnt    <= w_err_cnt_n;
    end
  end

  assign m_data    = r_data;
  assign m_valid   = r_valid;
  assign m_last    = r_last;
  assign m_err     = r_err;
  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_rmii_rx_framer.sv
// Self-checking bench for rmii_rx_framer: frames are built as byte lists and the
// expected payload stream is derived from frame length and FCS validity.
module tb_rmii_rx_framer;

  localparam int MAX_LEN = 1522;
  localparam int MIN_LEN = 64;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        crs_dv = 1'b0;
  logic [1:0]  rxd = 2'b00;
  logic [7:0]  m_data;
  logic        m_valid, m_last, m_err;
  logic [15:0] frame_cnt, err_cnt;

  always #10 clk = ~clk;

  rmii_rx_framer #(
    .MIN_PREAMBLE (4),
    .MAX_LEN      (MAX_LEN),
    .MIN_LEN      (MIN_LEN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rmii_crs_dv (crs_dv),
    .rmii_rxd    (rxd),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_last      (m_last),
    .m_err       (m_err),
    .frame_cnt   (frame_cnt),
    .err_cnt     (err_cnt)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_frames = 0;
  int exp_errs   = 0;
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];

  // Strobe capture; flags must stay low whenever m_valid is low.
  always @(negedge clk) begin
    if (m_valid) begin
      got_q.push_back({m_last, m_err, m_data});
    end else begin
      n_cmp++;
      if ((m_last !== 1'b0) || (m_err !== 1'b0)) begin
        n_fail++;
        $display("FAIL idle_flags: last=%b err=%b, required 0 0 while m_valid=0", m_last, m_err);
      end
    end
  end

  function automatic logic [31:0] fcs_of(input byte_q_t b, input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic byte_q_t with_fcs(input byte_q_t b);
    byte_q_t r;
    logic [31:0] f;
    r = b;
    f = fcs_of(b, b.size());
    for (int k = 0; k < 4; k++) r.push_back(f[8*k +: 8]);
    return r;
  endfunction

  // Expected strobes and counter deltas for a received frame of committed bytes b.
  task automatic model_frame(input byte_q_t b, input bit misalign);
    int n;
    logic bad;
    n = b.size();
    if (n > MAX_LEN) begin
      for (int i = 0; i < MAX_LEN - 4; i++)
        exp_q.push_back({(i == MAX_LEN - 5), (i == MAX_LEN - 5), b[i]});
      exp_frames++;
      exp_errs++;
    end else if (n < 5) begin
      exp_errs++;
    end else begin
      bad = (fcs_of(b, n - 4) != {b[n-1], b[n-2], b[n-3], b[n-4]}) || misalign || (n < MIN_LEN);
      for (int i = 0; i < n - 4; i++)
        exp_q.push_back({(i == n - 5), (i == n - 5) && bad, b[i]});
      exp_frames++;
      if (bad) exp_errs++;
    end
  endtask

  task automatic drive(input logic dv, input logic [1:0] d);
    @(negedge clk);
    crs_dv = dv;
    rxd    = d;
  endtask

  task automatic send_frame(input byte_q_t b, input int npre, input bit toggle, input bit extra);
    logic [1:0] dib[$];
    logic [7:0] v;
    logic       dv;
    int         start;
    for (int i = 0; i < b.size(); i++) begin
      v = b[i];
      for (int k = 0; k < 4; k++) dib.push_back(v[2*k +: 2]);
    end
    if (extra) dib.push_back(2'($urandom_range(3)));
    for (int i = 0; i < npre; i++) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
    start = dib.size() - 8;
    foreach (dib[i]) begin
      if (toggle && (i >= start)) dv = (((i - start) % 2) == 1);
      else dv = 1'b1;
      drive(dv, dib[i]);
    end
    repeat (4) drive(1'b0, 2'b00);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) drive(1'b0, 2'b00);
    n_cmp++;
    if ({m_valid, m_last, m_err, m_data} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid/last/err/data=%b, required all 0", {m_valid, m_last, m_err, m_data});
    end
    n_cmp++;
    if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d, required 0", frame_cnt); end
    n_cmp++;
    if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d, required 0", err_cnt); end
    rst = 1'b0;
    repeat (3) drive(1'b0, 2'b00);
  endtask

  task automatic test_good_frame();
    byte_q_t b;
    for (int i = 0; i < 60; i++) b.push_back(8'(i));
    b = with_fcs(b);
    model_frame(b, 1'b0);
    send_frame(b, 28, 1'b0, 1'b0);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL good_count: got %0d strobes, required %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL good_strobe[%0d]: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++;
    if (frame_cnt !== 16'(exp_frames)) begin n_fail++; $display("FAIL good_frame_cnt: got %0d, required %0d", frame_cnt, exp_frames); end
    n_cmp++;
    if (err_cnt !== 16'(exp_errs)) begin n_fail++; $display("FAIL good_err_cnt: got %0d, required %0d", err_cnt, exp_errs); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_bad_crc();
    byte_q_t b;
    for (int i = 0; i < 60; i++) b.push_back(8'(i));
    b = with_fcs(b);
    b[10] = b[10] ^ 8'h01;
    model_frame(b, 1'b0);
    send_frame(b, 28, 1'b0, 1'b0);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL crc_count: got %0d strobes, required %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL crc_strobe[%0d]: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++;
    if (err_cnt !== 16'(exp_errs)) begin n_fail++; $display("FAIL crc_err_cnt: got %0d, required %0d", err_cnt, exp_errs); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_crs_toggle();
    byte_q_t b;
    for (int i = 0; i < 60; i++) b.push_back(8'(i));
    b = with_fcs(b);
    model_frame(b, 1'b0);
    send_frame(b, 28, 1'b1, 1'b0);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL toggle_count: got %0d strobes, required %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL toggle_strobe[%0d]: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++;
    if (frame_cnt !== 16'(exp_frames)) begin n_fail++; $display("FAIL toggle_frame_cnt: got %0d, required %0d", frame_cnt, exp_frames); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_alignment();
    byte_q_t b;
    for (int i = 0; i < 60; i++) b.push_back(8'($urandom));
    b = with_fcs(b);
    model_frame(b, 1'b1);
    send_frame(b, 12, 1'b0, 1'b1);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL align_count: got %0d strobes, required %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL align_strobe[%0d]: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++;
    if (err_cnt !== 16'(exp_errs)) begin n_fail++; $display("FAIL align_err_cnt: got %0d, required %0d", err_cnt, exp_errs); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_runt();
    byte_q_t b;
    int plen[3] = '{59, 1, 0};
    for (int t = 0; t < 3; t++) begin
      b.delete();
      for (int i = 0; i < plen[t]; i++) b.push_back(8'($urandom));
      b = with_fcs(b);
      model_frame(b, 1'b0);
      send_frame(b, 4, 1'b0, 1'b0);
      n_cmp++;
      if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL runt%0d_count: got %0d strobes, required %0d", t, got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL runt%0d_strobe[%0d]: got %h, required %h", t, i, got_q[i], exp_q[i]); end
      end
      n_cmp++;
      if ({frame_cnt, err_cnt} !== {16'(exp_frames), 16'(exp_errs)}) begin
        n_fail++; $display("FAIL runt%0d_counters: got %0d/%0d, required %0d/%0d", t, frame_cnt, err_cnt, exp_frames, exp_errs);
      end
      got_q.delete(); exp_q.delete();
    end
  endtask

  task automatic test_overlength();
    byte_q_t b;
    for (int i = 0; i < 1596; i++) b.push_back(8'($urandom));
    b = with_fcs(b);
    model_frame(b, 1'b0);
    send_frame(b, 28, 1'b0, 1'b0);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL long_count: got %0d strobes, required %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL long_strobe[%0d]: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++;
    if ({frame_cnt, err_cnt} !== {16'(exp_frames), 16'(exp_errs)}) begin
      n_fail++; $display("FAIL long_counters: got %0d/%0d, required %0d/%0d", frame_cnt, err_cnt, exp_frames, exp_errs);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_midframe();
    byte_q_t b;
    logic [7:0] v;
    for (int i = 0; i < 60; i++) b.push_back(8'($urandom));
    b = with_fcs(b);
    for (int i = 0; i < 28; i++) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
    for (int i = 0; i < 20; i++) begin
      v = b[i];
      for (int k = 0; k < 4; k++) drive(1'b1, v[2*k +: 2]);
    end
    v = b[20];
    drive(1'b1, v[1:0]);
    rst = 1'b1;
    drive(1'b1, v[3:2]);
    rst = 1'b0;
    got_q.delete();
    drive(1'b1, v[5:4]);
    drive(1'b1, v[7:6]);
    for (int i = 21; i < b.size(); i++) begin
      v = b[i];
      for (int k = 0; k < 4; k++) drive(1'b1, v[2*k +: 2]);
    end
    repeat (4) drive(1'b0, 2'b00);
    exp_frames = 0;
    exp_errs   = 0;
    n_cmp++;
    if (got_q.size() != 0) begin n_fail++; $display("FAIL rstmid_strobes: got %0d strobes after reset, required 0", got_q.size()); end
    n_cmp++;
    if ({frame_cnt, err_cnt} !== 32'd0) begin n_fail++; $display("FAIL rstmid_counters: got %0d/%0d, required 0/0", frame_cnt, err_cnt); end
    got_q.delete();
    b.delete();
    for (int i = 0; i < 70; i++) b.push_back(8'($urandom));
    b = with_fcs(b);
    model_frame(b, 1'b0);
    send_frame(b, 28, 1'b0, 1'b0);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rstmid_next_count: got %0d strobes, required %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rstmid_next_strobe[%0d]: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++;
    if ({frame_cnt, err_cnt} !== {16'(exp_frames), 16'(exp_errs)}) begin
      n_fail++; $display("FAIL rstmid_next_counters: got %0d/%0d, required %0d/%0d", frame_cnt, err_cnt, exp_frames, exp_errs);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    byte_q_t b;
    bit tog, ext;
    for (int t = 0; t < 8; t++) begin
      b.delete();
      for (int i = 0; i < int'($urandom_range(0, 90)); i++) b.push_back(8'($urandom));
      b = with_fcs(b);
      if ($urandom_range(2) == 0) b[$urandom_range(b.size() - 1)] ^= 8'(1 << $urandom_range(7));
      tog = ($urandom_range(1) == 1);
      ext = ($urandom_range(3) == 0);
      model_frame(b, ext);
      send_frame(b, int'($urandom_range(4, 30)), tog, ext);
      n_cmp++;
      if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b%0d_count: got %0d strobes, required %0d", t, got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b%0d_strobe[%0d]: got %h, required %h", t, i, got_q[i], exp_q[i]); end
      end
      n_cmp++;
      if ({frame_cnt, err_cnt} !== {16'(exp_frames), 16'(exp_errs)}) begin
        n_fail++; $display("FAIL b2b%0d_counters: got %0d/%0d, required %0d/%0d", t, frame_cnt, err_cnt, exp_frames, exp_errs);
      end
      got_q.delete(); exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_crc();
    test_crs_toggle();
    test_alignment();
    test_runt();
    test_overlength();
    test_reset_midframe();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rmii_rx_framer.md
Name: rmii_rx_framer

Overview:
- Receive-side Ethernet front end for the iCEBreaker PMOD PHY (LAN8720-class, RMII, 100 Mb/s).
- Samples the RMII dibit stream on the 50 MHz PLL clock and strips preamble/SFD.
- Assembles bytes, checks the FCS (CRC-32) and frame length.
- Presents a payload byte stream (FCS removed) with last/error flags to the PipelineC-generated core.

Parameters:
- MIN_PREAMBLE, 4, minimum count of consecutive 01 dibits (including the SFD's leading ones) before SFD is accepted
- MAX_LEN, 1522, maximum frame bytes including FCS; longer frames are truncated and flagged
- MIN_LEN, 64, minimum frame bytes including FCS; shorter frames are flagged as runts

Ports:
- clk  in  1  50 MHz RMII reference clock from the PLL; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rmii_crs_dv  in  1  RMII CRS_DV, already registered into the clk domain
- rmii_rxd  in  2  RMII RXD[1:0], already registered into the clk domain
- m_data  out  8  payload byte
- m_valid  out  1  one-cycle strobe, m_data valid; no backpressure
- m_last  out  1  qualifies m_valid, final payload byte of the frame
- m_err  out  1  qualifies m_last: CRC, alignment, runt or overlength error
- frame_cnt  out  16  frames ended with m_last, saturating at 0xFFFF
- err_cnt  out  16  frames ended with m_err or silently dropped, saturating at 0xFFFF

Behaviour:
- Reset:
  - All outputs 0; counters 0; CRC = 0xFFFFFFFF; delay line empty.
  - State = WAIT_IDLE. Reset mid-frame abandons the frame with no m_last.
- WAIT_IDLE: go to IDLE after crs_dv=0 on 2 consecutive cycles.
- IDLE: crs_dv=1 and rxd=01 → PREAMBLE, preamble count = 1.
- PREAMBLE:
  - rxd=01 → count++ (saturating).
  - rxd=11 with count ≥ MIN_PREAMBLE → DATA, dibit index 0.
  - rxd=11 with count < MIN_PREAMBLE, or rxd ∈ {00, 10} → DROP.
  - crs_dv=0 → IDLE.
- DATA, byte assembly:
  - Dibits are LSB first: dibit k lands in byte bits [2k+1:2k].
  - Each completed byte updates the CRC (reflected poly 0xEDB88320) and shifts into a 5-byte delay line.
- DATA, output:
  - When a byte shifts in with the line already full, the evicted oldest byte is output.
  - m_valid pulses 1 cycle after the 4th dibit, i.e. at most 1 strobe per 4 clocks.
- DATA, CRS_DV toggling:
  - A dibit sampled with crs_dv=0 is held pending.
  - If the next cycle has crs_dv=1, the pending dibit is committed, then the current dibit.
  - If the next cycle has crs_dv=0, this is end of frame and the pending dibit is discarded.
- End of frame, cycle after detection:
  - If ≥5 bytes were received: emit the oldest delay-line byte (the last payload byte) with m_valid=1, m_last=1.
  - The remaining 4 bytes (FCS) are discarded.
  - m_err = (CRC register ≠ 0xDEBB20E3) | (dibit index ≠ 0) | (byte count < MIN_LEN).
  - frame_cnt++, plus err_cnt++ if m_err.
  - If <5 bytes were received: no output, err_cnt++.
  - Next state IDLE.
- Overlength: when the byte count would exceed MAX_LEN, the next output strobe carries m_last=1, m_err=1; counters update; state → DROP.
- DROP: ignore input; crs_dv=0 on 2 consecutive cycles → IDLE.
- Simultaneous events: end of frame coincident with completion of a 4th dibit commits that byte first; the end-of-frame strobe follows 1 cycle later. There is never more than one strobe per cycle.
- m_last and m_err are 0 whenever m_valid=0.

Decomposition:
- Shared package eth_rx_pkg:
  - state enum {WAIT_IDLE, IDLE, PREAMBLE, DATA, DROP}
  - CRC32_POLY_REFL = 0xEDB88320, CRC32_INIT = 0xFFFFFFFF, CRC32_RESIDUE = 0xDEBB20E3
  - ETH_FCS_BYTES = 4
- One sub-module: crc32_d8, combinational next-CRC for 8 data bits over a 32-bit state, reused later by the TX framer.

Test Plan:
- Good frame: 28×01, 11, 60-byte payload 0x00..0x3B, correct FCS → 60 strobes with data 0x00..0x3B, last only on 0x3B, m_err=0, frame_cnt=1, err_cnt=0.
- Same frame with payload byte 10 flipped → 60 strobes, m_last with m_err=1, err_cnt=1.
- Good frame where crs_dv toggles 0/1 on the final 8 dibits, then two lows → output identical to the good-frame case; no extra or missing bytes.
- Frame ending with an odd extra dibit (byte not complete) → m_last with m_err=1 (alignment).
- 1600-byte frame → strobe number 1518 has m_last=1, m_err=1; no strobes afterwards; next good frame received cleanly.
- rst asserted during byte 20 of a frame with crs_dv held high → no further strobes; that frame is not received; a following good frame after 2 idle cycles is received intact.
